// File: rtl/r5p_trace_pkg.sv
// ============================================================================
// Module      : r5p_trace_pkg
// Description : Shared record layout, FSM encodings and mode constants for
//               the r5p retired-instruction trace buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package r5p_trace_pkg;

    localparam int c_TRACE_XLEN = 32;

    typedef logic [1:0] trace_sta_t;

    localparam trace_sta_t c_ST_IDLE = 2'd0;
    localparam trace_sta_t c_ST_ARMD = 2'd1;
    localparam trace_sta_t c_ST_CAPT = 2'd2;
    localparam trace_sta_t c_ST_DONE = 2'd3;

    localparam logic c_MODE_STOP = 1'b0;
    localparam logic c_MODE_WRAP = 1'b1;

    typedef struct packed {
        logic [c_TRACE_XLEN-1:0] pc;
        logic [31:0]             ins;
        logic                    cmp;
        logic                    gpr_vld;
        logic [4:0]              gpr_wid;
        logic [c_TRACE_XLEN-1:0] gpr_wdt;
        logic                    lsu_vld;
        logic                    lsu_wen;
        logic                    lsu_mul;
        logic [c_TRACE_XLEN-1:0] lsu_adr;
        logic [c_TRACE_XLEN-1:0] lsu_dat;
    } trace_rec_t;

endpackage

`default_nettype wire

// File: rtl/r5p_trace_fifo.sv
// ============================================================================
// Module      : r5p_trace_fifo
// Description : Circular record buffer with optional overwrite-oldest on full
//               and a registered head-of-queue read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module r5p_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       ovw,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0] cnt,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_dout;

    logic          w_pop;
    logic          w_full;
    logic          w_wr;
    logic          w_rd_adv;
    logic [AW-1:0] w_rd_nxt;

    always_comb begin
        w_pop    = pop && (r_cnt != '0);
        w_full   = (r_cnt == CW'(DEPTH));
        w_wr     = push && (!w_full || w_pop || ovw);
        // Overwrite on full pushes the read pointer along with the write
        w_rd_adv = w_pop || (push && w_full && !w_pop && ovw);
        w_rd_nxt = w_rd_adv ? r_rd_ptr + AW'(1) : r_rd_ptr;
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_dout   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_nxt;
            case ({w_wr, w_rd_adv})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            // The new head may be the entry being written this very cycle
            r_dout <= (w_wr && (r_wr_ptr == w_rd_nxt)) ? din : r_mem[w_rd_nxt];
        end
    end

    assign dout = r_dout;
    assign cnt  = r_cnt;
    assign full = w_full;

endmodule

`default_nettype wire

// File: rtl/r5p_trace_buffer.sv
// ============================================================================
// Module      : r5p_trace_buffer
// Description : Retired-instruction trace capture: aligns IFU/LSU responses,
//               assembles one record per instruction and buffers it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module r5p_trace_buffer
    import r5p_trace_pkg::*;
#(
    parameter int XLEN  = c_TRACE_XLEN,
    parameter int DEPTH = 16,
    parameter int OVFW  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ctl_ena,
    input  logic                       ctl_mode,
    input  logic                       ctl_trg_ena,
    input  logic [XLEN-1:0]            ctl_trg_adr,
    input  logic                       ifu_trn,
    input  logic [XLEN-1:0]            ifu_adr,
    input  logic [31:0]                ifu_rdt,
    input  logic                       gpr_wen,
    input  logic [4:0]                 gpr_wid,
    input  logic [XLEN-1:0]            gpr_wdt,
    input  logic                       lsu_trn,
    input  logic                       lsu_wen,
    input  logic [XLEN-1:0]            lsu_adr,
    input  logic [XLEN-1:0]            lsu_wdt,
    input  logic [XLEN-1:0]            lsu_rdt,
    output logic                       rec_vld,
    input  logic                       rec_rdy,
    output trace_rec_t                 rec_dat,
    output logic [$clog2(DEPTH+1)-1:0] sts_cnt,
    output logic [OVFW-1:0]            sts_ovf,
    output logic [1:0]                 sts_sta
);

    logic            r_ifu_rsp;
    logic [XLEN-1:0] r_ifu_adr;
    logic            r_lsu_rsp;
    logic            r_lsu_wen;
    logic [XLEN-1:0] r_lsu_adr;
    logic [XLEN-1:0] r_lsu_wdt;

    trace_rec_t      r_pend;
    logic            r_pend_vld;
    trace_sta_t      r_state;
    logic [OVFW-1:0] r_ovf;

    trace_rec_t      w_pend_upd;
    trace_rec_t      w_new_rec;
    logic            w_trig;
    logic            w_load;
    logic            w_push;
    logic            w_pop;
    logic            w_ovf_evt;
    logic            w_full;
    logic [$clog2(DEPTH+1)-1:0] w_cnt;
    trace_rec_t      w_fifo_dout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ifu_rsp <= 1'b0;
            r_ifu_adr <= '0;
            r_lsu_rsp <= 1'b0;
            r_lsu_wen <= 1'b0;
            r_lsu_adr <= '0;
            r_lsu_wdt <= '0;
        end else begin
            r_ifu_rsp <= ifu_trn;
            r_lsu_rsp <= lsu_trn;
            if (ifu_trn) begin
                r_ifu_adr <= ifu_adr;
            end
            if (lsu_trn) begin
                r_lsu_wen <= lsu_wen;
                r_lsu_adr <= lsu_adr;
                r_lsu_wdt <= lsu_wdt;
            end
        end
    end

    // Same-cycle GPR/LSU events belong to the record that is about to commit
    always_comb begin
        w_pend_upd = r_pend;
        if (r_pend_vld) begin
            if (gpr_wen && (gpr_wid != 5'd0)) begin
                w_pend_upd.gpr_vld = 1'b1;
                w_pend_upd.gpr_wid = gpr_wid;
                w_pend_upd.gpr_wdt = gpr_wdt;
            end
            if (r_lsu_rsp) begin
                w_pend_upd.lsu_mul = r_pend.lsu_vld;
                w_pend_upd.lsu_vld = 1'b1;
                w_pend_upd.lsu_wen = r_lsu_wen;
                w_pend_upd.lsu_adr = r_lsu_adr;
                w_pend_upd.lsu_dat = r_lsu_wen ? r_lsu_wdt : lsu_rdt;
            end
        end

        w_new_rec     = '0;
        w_new_rec.pc  = r_ifu_adr;
        w_new_rec.cmp = (ifu_rdt[1:0] != 2'b11);
        w_new_rec.ins = w_new_rec.cmp ? {16'h0000, ifu_rdt[15:0]} : ifu_rdt;

        w_trig    = (r_state == c_ST_ARMD) && r_ifu_rsp && (r_ifu_adr == ctl_trg_adr);
        w_load    = ctl_ena && r_ifu_rsp && ((r_state == c_ST_CAPT) || w_trig);
        w_push    = ctl_ena && (r_state == c_ST_CAPT) && r_ifu_rsp && r_pend_vld;
        w_pop     = rec_rdy && (w_cnt != '0);
        w_ovf_evt = w_push && w_full && !w_pop;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
        end else if (!ctl_ena) begin
            r_pend_vld <= 1'b0;
        end else if (w_load) begin
            r_pend     <= w_new_rec;
            r_pend_vld <= 1'b1;
        end else begin
            r_pend     <= w_pend_upd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else if (!ctl_ena) begin
            r_state <= c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: r_state <= ctl_trg_ena ? c_ST_ARMD : c_ST_CAPT;
                c_ST_ARMD: if (w_trig) r_state <= c_ST_CAPT;
                c_ST_CAPT: if (w_ovf_evt && (ctl_mode == c_MODE_STOP)) r_state <= c_ST_DONE;
                default:   r_state <= r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= '0;
        end else if (w_ovf_evt && (r_ovf != '1)) begin
            r_ovf <= r_ovf + OVFW'(1);
        end
    end

    r5p_trace_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(trace_rec_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (rec_rdy),
        .ovw   (ctl_mode == c_MODE_WRAP),
        .din   (w_pend_upd),
        .dout  (w_fifo_dout),
        .cnt   (w_cnt),
        .full  (w_full)
    );

    assign rec_vld = (w_cnt != '0);
    assign rec_dat = w_fifo_dout;
    assign sts_cnt = w_cnt;
    assign sts_ovf = r_ovf;
    assign sts_sta = r_state;

endmodule

`default_nettype wire

// File: tb/tb_r5p_trace_buffer.sv
// ============================================================================
// Module      : tb_r5p_trace_buffer
// Description : Scoreboard bench for r5p_trace_buffer with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_r5p_trace_buffer;
    import r5p_trace_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ctl_ena, ctl_mode, ctl_trg_ena;
    logic [31:0] ctl_trg_adr;
    logic        ifu_trn;
    logic [31:0] ifu_adr, ifu_rdt;
    logic        gpr_wen;
    logic [4:0]  gpr_wid;
    logic [31:0] gpr_wdt;
    logic        lsu_trn, lsu_wen;
    logic [31:0] lsu_adr, lsu_wdt, lsu_rdt;
    logic        rec_vld, rec_rdy;
    trace_rec_t  rec_dat;
    logic [4:0]  sts_cnt;
    logic [15:0] sts_ovf;
    logic [1:0]  sts_sta;

    int n_chk  = 0;
    int n_pass = 0;
    trace_rec_t exp_q[$];

    always #5 clk = ~clk;

    r5p_trace_buffer #(.XLEN(32), .DEPTH(16), .OVFW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ctl_ena(ctl_ena), .ctl_mode(ctl_mode), .ctl_trg_ena(ctl_trg_ena), .ctl_trg_adr(ctl_trg_adr),
        .ifu_trn(ifu_trn), .ifu_adr(ifu_adr), .ifu_rdt(ifu_rdt),
        .gpr_wen(gpr_wen), .gpr_wid(gpr_wid), .gpr_wdt(gpr_wdt),
        .lsu_trn(lsu_trn), .lsu_wen(lsu_wen), .lsu_adr(lsu_adr), .lsu_wdt(lsu_wdt), .lsu_rdt(lsu_rdt),
        .rec_vld(rec_vld), .rec_rdy(rec_rdy), .rec_dat(rec_dat),
        .sts_cnt(sts_cnt), .sts_ovf(sts_ovf), .sts_sta(sts_sta)
    );

    // Monitor: every accepted record is checked against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && rec_vld && rec_rdy) begin
            trace_rec_t e;
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL rec_unexpected: got pc=%h ins=%h, required none", rec_dat.pc, rec_dat.ins);
            end else begin
                e = exp_q.pop_front();
                if (rec_dat === e) n_pass++;
                else $display("FAIL rec_dat: got %h, required %h", rec_dat, e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic trace_rec_t mk(input logic [31:0] pc, input logic [31:0] ins, input logic cmp);
        trace_rec_t r;
        r     = '0;
        r.pc  = pc;
        r.ins = ins;
        r.cmp = cmp;
        return r;
    endfunction

    task automatic fetch(input logic [31:0] pc, input logic [31:0] ins);
        ifu_trn = 1'b1; ifu_adr = pc;
        step();
        ifu_trn = 1'b0; ifu_rdt = ins;
        step();
        ifu_rdt = '0;
    endtask

    task automatic gpr(input logic [4:0] wid, input logic [31:0] wdt);
        gpr_wen = 1'b1; gpr_wid = wid; gpr_wdt = wdt;
        step();
        gpr_wen = 1'b0;
    endtask

    task automatic lsu(input logic wen, input logic [31:0] adr, input logic [31:0] wdt, input logic [31:0] rdt);
        lsu_trn = 1'b1; lsu_wen = wen; lsu_adr = adr; lsu_wdt = wdt;
        step();
        lsu_trn = 1'b0; lsu_rdt = rdt;
        step();
        lsu_rdt = '0;
    endtask

    task automatic restart(input logic mode, input logic trg_en, input logic [31:0] trg);
        ctl_ena = 1'b0;
        step();
        ctl_mode = mode; ctl_trg_ena = trg_en; ctl_trg_adr = trg; ctl_ena = 1'b1;
        step();
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 64 && exp_q.size() != 0; k++) step();
        step();
        chk(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        trace_rec_t r;
        rst_n = 1'b0; ctl_ena = 0; ctl_mode = 0; ctl_trg_ena = 0; ctl_trg_adr = '0;
        ifu_trn = 0; ifu_adr = '0; ifu_rdt = '0; gpr_wen = 0; gpr_wid = '0; gpr_wdt = '0;
        lsu_trn = 0; lsu_wen = 0; lsu_adr = '0; lsu_wdt = '0; lsu_rdt = '0; rec_rdy = 0;
        step(); step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_vld", {31'b0, rec_vld}, 0);
        chk("rst_cnt", {27'b0, sts_cnt}, 0);
        chk("rst_ovf", {16'b0, sts_ovf}, 0);
        chk("rst_sta", {30'b0, sts_sta}, c_ST_IDLE);
        chk("rst_dat", rec_dat.pc, 0);

        // Basic capture: addi x1,x0,5 then sw
        rec_rdy = 1'b1;
        restart(c_MODE_STOP, 1'b0, '0);
        chk("capt_sta", {30'b0, sts_sta}, c_ST_CAPT);
        r = mk(32'h80, 32'h00500093, 1'b0);
        r.gpr_vld = 1'b1; r.gpr_wid = 5'd1; r.gpr_wdt = 32'h5;
        exp_q.push_back(r);
        r = mk(32'h84, 32'h0020a023, 1'b0);
        r.lsu_vld = 1'b1; r.lsu_wen = 1'b1; r.lsu_adr = 32'h1000; r.lsu_dat = 32'hAA;
        exp_q.push_back(r);
        fetch(32'h80, 32'h00500093);
        gpr(5'd1, 32'h5);
        fetch(32'h84, 32'h0020a023);
        lsu(1'b1, 32'h1000, 32'hAA, 32'hDEAD);
        fetch(32'h88, 32'h00000013);
        wait_drain("basic_drain");

        // Trigger on 0x108
        restart(c_MODE_STOP, 1'b1, 32'h108);
        chk("armd_sta0", {30'b0, sts_sta}, c_ST_ARMD);
        fetch(32'h100, 32'h13);
        fetch(32'h104, 32'h13);
        chk("armd_sta1", {30'b0, sts_sta}, c_ST_ARMD);
        chk("armd_cnt", {27'b0, sts_cnt}, 0);
        fetch(32'h108, 32'h13);
        chk("trg_sta", {30'b0, sts_sta}, c_ST_CAPT);
        exp_q.push_back(mk(32'h108, 32'h13, 1'b0));
        fetch(32'h10c, 32'h13);
        exp_q.push_back(mk(32'h10c, 32'h13, 1'b0));
        fetch(32'h110, 32'h13);
        wait_drain("trg_drain");

        // Mode 0: stop on full
        rec_rdy = 1'b0;
        restart(c_MODE_STOP, 1'b0, '0);
        for (int i = 0; i < 21; i++) fetch(32'h400 + 32'(4*i), 32'h13 | (32'(i) << 7));
        chk("stop_cnt", {27'b0, sts_cnt}, 16);
        chk("stop_ovf", {16'b0, sts_ovf}, 1);
        chk("stop_sta", {30'b0, sts_sta}, c_ST_DONE);
        for (int i = 0; i < 16; i++) exp_q.push_back(mk(32'h400 + 32'(4*i), 32'h13 | (32'(i) << 7), 1'b0));
        rec_rdy = 1'b1;
        wait_drain("stop_drain");
        chk("stop_empty", {31'b0, rec_vld}, 0);

        // Mode 1: wrap, oldest overwritten
        do_reset();
        rec_rdy = 1'b0;
        restart(c_MODE_WRAP, 1'b0, '0);
        for (int i = 0; i < 21; i++) fetch(32'h400 + 32'(4*i), 32'h13 | (32'(i) << 7));
        chk("wrap_cnt", {27'b0, sts_cnt}, 16);
        chk("wrap_ovf", {16'b0, sts_ovf}, 4);
        chk("wrap_sta", {30'b0, sts_sta}, c_ST_CAPT);
        chk("wrap_head", rec_dat.pc, 32'h410);
        for (int i = 4; i < 20; i++) exp_q.push_back(mk(32'h400 + 32'(4*i), 32'h13 | (32'(i) << 7), 1'b0));
        rec_rdy = 1'b1;
        wait_drain("wrap_drain");

        // Compressed encoding, x0 write, double LSU access
        restart(c_MODE_WRAP, 1'b0, '0);
        exp_q.push_back(mk(32'h200, 32'h00004501, 1'b1));
        r = mk(32'h202, 32'h13, 1'b0);
        r.lsu_vld = 1'b1; r.lsu_wen = 1'b1; r.lsu_mul = 1'b1; r.lsu_adr = 32'h2004; r.lsu_dat = 32'h22;
        exp_q.push_back(r);
        fetch(32'h200, 32'hABCD4501);
        gpr(5'd0, 32'h55);
        fetch(32'h202, 32'h13);
        lsu(1'b0, 32'h2000, 32'h0, 32'h11);
        lsu(1'b1, 32'h2004, 32'h22, 32'h0);
        fetch(32'h204, 32'h13);
        wait_drain("cmp_drain");

        // Reset in the middle of a capture with an in-flight fetch
        rec_rdy = 1'b0;
        restart(c_MODE_STOP, 1'b0, '0);
        for (int i = 0; i < 6; i++) fetch(32'h300 + 32'(4*i), 32'h13);
        chk("mid_cnt", {27'b0, sts_cnt}, 5);
        rst_n = 1'b0; ifu_trn = 1'b1; ifu_adr = 32'h500;
        step();
        ifu_trn = 1'b0; ifu_rdt = 32'h13; ctl_ena = 1'b0;
        @(negedge clk);
        chk("mid_vld", {31'b0, rec_vld}, 0);
        chk("mid_rcnt", {27'b0, sts_cnt}, 0);
        chk("mid_ovf", {16'b0, sts_ovf}, 0);
        chk("mid_sta", {30'b0, sts_sta}, c_ST_IDLE);
        rst_n = 1'b1;
        step(); step();
        chk("post_cnt", {27'b0, sts_cnt}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
